// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-side bus of the two-port image memory arbiter.
// The slave modport is the arbiter; master is the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              arb_en;
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dataW;
    logic [DATA_W-1:0] mem_dataR;
    logic [15:0]       gcnt0, gcnt1;

    modport slave (
        input  arb_en, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataR,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_dataW,
               gcnt0, gcnt1
    );

    modport master (
        output arb_en, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataR,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_dataW,
               gcnt0, gcnt1
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port image memory: pixel reads on port 0,
// result write-back on port 1, with tagged read return and grant counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    logic              rr_ptr;
    logic              en;
    logic              gnt0, gnt1;
    logic              rd_issue;
    logic [RD_LAT:1]   vld_pipe;
    logic [RD_LAT:1]   id_pipe;
    logic [15:0]       gcnt0, gcnt1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dataW;

    // Reset gates the grant so nothing reaches memory while held in reset.
    always_comb begin
        en   = reset & bus.arb_en;
        gnt1 = en & bus.req1 & (~bus.req0 | ((FIXED_PRIO == 0) & rr_ptr));
        gnt0 = en & bus.req0 & ~gnt1;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_dataW = '0;
        if (gnt0) begin
            mem_we    = bus.we0;
            mem_addr  = bus.addr0;
            mem_dataW = bus.wdata0;
        end else if (gnt1) begin
            mem_we    = bus.we1;
            mem_addr  = bus.addr1;
            mem_dataW = bus.wdata1;
        end
    end

    assign rd_issue = (gnt0 | gnt1) & ~mem_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= 1'b0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            gcnt0    <= '0;
            gcnt1    <= '0;
        end else begin
            if (gnt0 | gnt1) rr_ptr <= gnt0;
            // Tag stage RD_LAT lines up with mem_dataR for the issuing read.
            vld_pipe[1] <= rd_issue;
            id_pipe[1]  <= gnt1;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
            if (gnt0 && gcnt0 != 16'hFFFF) gcnt0 <= gcnt0 + 16'd1;
            if (gnt1 && gcnt1 != 16'hFFFF) gcnt1 <= gcnt1 + 16'd1;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_en    = gnt0 | gnt1;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_dataW = mem_dataW;
    assign bus.rvalid0   = vld_pipe[RD_LAT] & ~id_pipe[RD_LAT];
    assign bus.rvalid1   = vld_pipe[RD_LAT] &  id_pipe[RD_LAT];
    assign bus.rdata     = bus.mem_dataR;
    assign bus.gcnt0     = gcnt0;
    assign bus.gcnt1     = gcnt1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance (RD_LAT=1) and fixed-priority
// instance (RD_LAT=3) sharing clock and reset.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) a ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) f ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset(reset), .bus(a));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset), .bus(f));

    always #5 clk = ~clk;

    // Memory model: data for an address is {16'hA5A5, addr}, one cycle later.
    always @(posedge clk) a.mem_dataR <= {16'hA5A5, a.mem_addr};
    always @(posedge clk) f.mem_dataR <= {16'h5A5A, f.mem_addr};

    task automatic idle_all;
        a.req0 = 0; a.req1 = 0; a.we0 = 0; a.we1 = 0; a.arb_en = 1;
        a.addr0 = '0; a.addr1 = '0; a.wdata0 = '0; a.wdata1 = '0;
        f.req0 = 0; f.req1 = 0; f.we0 = 0; f.we1 = 0; f.arb_en = 1;
        f.addr0 = '0; f.addr1 = '0; f.wdata0 = '0; f.wdata1 = '0;
    endtask

    task automatic do_reset;
        @(negedge clk); idle_all(); reset = 0;
        @(negedge clk); reset = 1;
    endtask

    task automatic test_reset;
        @(negedge clk); idle_all(); reset = 0; a.req0 = 1; a.addr0 = 16'h0010;
        #1;
        total++; if (a.gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b exp=0", a.gnt0); end
        total++; if (a.mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", a.mem_en); end
        total++; if ({a.rvalid0, a.rvalid1} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {a.rvalid0, a.rvalid1}); end
        total++; if ({a.gcnt0, a.gcnt1} !== 32'h0) begin bad++; $display("FAIL reset_gcnt got=%h exp=0", {a.gcnt0, a.gcnt1}); end
        a.req0 = 0;
        @(negedge clk); reset = 1;
    endtask

    task automatic test_single_read;
        do_reset();
        @(negedge clk); a.req0 = 1; a.we0 = 0; a.addr0 = 16'h0010; #1;
        total++; if (a.gnt0 !== 1'b1 || a.gnt1 !== 1'b0) begin bad++; $display("FAIL single_gnt got=%b%b exp=10", a.gnt0, a.gnt1); end
        total++; if (a.mem_en !== 1'b1 || a.mem_we !== 1'b0) begin bad++; $display("FAIL single_mem_en_we got=%b%b exp=10", a.mem_en, a.mem_we); end
        total++; if (a.mem_addr !== 16'h0010) begin bad++; $display("FAIL single_addr got=%h exp=0010", a.mem_addr); end
        @(negedge clk); a.req0 = 0; #1;
        total++; if (a.rvalid0 !== 1'b1 || a.rvalid1 !== 1'b0) begin bad++; $display("FAIL single_rvalid got=%b%b exp=10", a.rvalid0, a.rvalid1); end
        total++; if (a.rdata !== 32'hA5A50010) begin bad++; $display("FAIL single_rdata got=%h exp=a5a50010", a.rdata); end
        total++; if (a.gcnt0 !== 16'd1) begin bad++; $display("FAIL single_gcnt0 got=%0d exp=1", a.gcnt0); end
        @(negedge clk); #1;
        total++; if (a.rvalid0 !== 1'b0) begin bad++; $display("FAIL single_rvalid_drop got=%b exp=0", a.rvalid0); end
    endtask

    task automatic test_round_robin;
        logic e0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a.req0 = 1; a.req1 = 1; a.addr0 = 16'h0100; a.addr1 = 16'h0200; #1;
            e0 = (i % 2 == 0);
            total++; if (a.gnt0 !== e0 || a.gnt1 !== !e0) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b%b exp=%b%b", i, a.gnt0, a.gnt1, e0, !e0); end
            if (i > 0) begin
                total++; if (a.rvalid0 !== !e0 || a.rvalid1 !== e0) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp=%b%b", i, a.rvalid0, a.rvalid1, !e0, e0); end
                total++; if (a.rdata !== (e0 ? 32'hA5A50200 : 32'hA5A50100)) begin bad++; $display("FAIL rr_rdata cyc=%0d got=%h", i, a.rdata); end
            end
        end
        @(negedge clk); a.req0 = 0; a.req1 = 0; #1;
        total++; if (a.rvalid1 !== 1'b1 || a.rdata !== 32'hA5A50200) begin bad++; $display("FAIL rr_last got=%b/%h exp=1/a5a50200", a.rvalid1, a.rdata); end
        total++; if (a.gcnt0 !== 16'd3 || a.gcnt1 !== 16'd3) begin bad++; $display("FAIL rr_gcnt got=%0d/%0d exp=3/3", a.gcnt0, a.gcnt1); end
    endtask

    task automatic test_write;
        do_reset();
        @(negedge clk); a.req1 = 1; a.we1 = 1; a.addr1 = 16'h6300; a.wdata1 = 32'hFFFEFDFC; #1;
        total++; if (a.gnt1 !== 1'b1 || a.mem_we !== 1'b1) begin bad++; $display("FAIL wr_gnt_we got=%b%b exp=11", a.gnt1, a.mem_we); end
        total++; if (a.mem_addr !== 16'h6300) begin bad++; $display("FAIL wr_addr got=%h exp=6300", a.mem_addr); end
        total++; if (a.mem_dataW !== 32'hFFFEFDFC) begin bad++; $display("FAIL wr_data got=%h exp=fffefdfc", a.mem_dataW); end
        @(negedge clk); a.req1 = 0; a.we1 = 0; #1;
        total++; if ({a.rvalid0, a.rvalid1} !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=00", {a.rvalid0, a.rvalid1}); end
        total++; if ({a.mem_en, a.mem_we, a.mem_addr, a.mem_dataW} !== 50'h0) begin bad++; $display("FAIL idle_bus got=%b%b/%h/%h exp=0", a.mem_en, a.mem_we, a.mem_addr, a.mem_dataW); end
    endtask

    task automatic test_arb_en;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); a.arb_en = 0; a.req0 = 1; a.addr0 = 16'h0020; #1;
            total++; if (a.gnt0 !== 1'b0 || a.mem_en !== 1'b0) begin bad++; $display("FAIL arboff cyc=%0d got=%b%b exp=00", i, a.gnt0, a.mem_en); end
        end
        @(negedge clk); a.arb_en = 1; #1;
        total++; if (a.gnt0 !== 1'b1 || a.mem_addr !== 16'h0020) begin bad++; $display("FAIL arbon got=%b/%h exp=1/0020", a.gnt0, a.mem_addr); end
        // Read in flight when arbitration is switched off must still return.
        @(negedge clk); a.req0 = 0; a.arb_en = 0; #1;
        total++; if (a.rvalid0 !== 1'b1 || a.rdata !== 32'hA5A50020) begin bad++; $display("FAIL inflight got=%b/%h exp=1/a5a50020", a.rvalid0, a.rdata); end
        @(negedge clk); a.arb_en = 1;
    endtask

    task automatic test_withdraw;
        do_reset();
        @(negedge clk); a.arb_en = 0; a.req0 = 1; #1;
        @(negedge clk); a.req0 = 0; a.arb_en = 1; #1;
        total++; if ({a.gnt0, a.gnt1} !== 2'b00) begin bad++; $display("FAIL withdraw_gnt got=%b exp=00", {a.gnt0, a.gnt1}); end
        @(negedge clk); a.req0 = 1; a.req1 = 1; #1;
        total++; if (a.gnt0 !== 1'b1 || a.gnt1 !== 1'b0) begin bad++; $display("FAIL withdraw_ptr got=%b%b exp=10", a.gnt0, a.gnt1); end
        @(negedge clk); a.req0 = 0; a.req1 = 0;
    endtask

    task automatic test_fixed_prio;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); f.req0 = 1; f.req1 = 1; #1;
            total++; if (f.gnt0 !== 1'b1 || f.gnt1 !== 1'b0) begin bad++; $display("FAIL fp_gnt cyc=%0d got=%b%b exp=10", i, f.gnt0, f.gnt1); end
        end
        @(negedge clk); f.req0 = 0; #1;
        total++; if (f.gnt1 !== 1'b1 || f.gnt0 !== 1'b0) begin bad++; $display("FAIL fp_gnt1 got=%b%b exp=01", f.gnt0, f.gnt1); end
        @(negedge clk); f.req1 = 0; #1;
        total++; if (f.gcnt0 !== 16'd4 || f.gcnt1 !== 16'd1) begin bad++; $display("FAIL fp_gcnt got=%0d/%0d exp=4/1", f.gcnt0, f.gcnt1); end
    endtask

    task automatic test_latency3;
        logic exp_v;
        do_reset();
        @(negedge clk); f.req1 = 1; f.addr1 = 16'h0ABC; #1;
        total++; if (f.gnt1 !== 1'b1) begin bad++; $display("FAIL lat3_gnt got=%b exp=1", f.gnt1); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); f.req1 = 0; #1;
            exp_v = (i == 3);
            total++; if (f.rvalid1 !== exp_v || f.rvalid0 !== 1'b0) begin bad++; $display("FAIL lat3_rvalid cyc=%0d got=%b%b exp=0%b", i, f.rvalid0, f.rvalid1, exp_v); end
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        @(negedge clk); f.req0 = 1; f.addr0 = 16'h0044; a.req0 = 1; a.addr0 = 16'h0044; #1;
        total++; if (f.gnt0 !== 1'b1 || a.gnt0 !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b%b exp=11", f.gnt0, a.gnt0); end
        @(negedge clk); f.req0 = 0; a.req0 = 0; reset = 0; #1;
        total++; if (f.rvalid0 !== 1'b0 || a.rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_rvalid_rst got=%b%b exp=00", f.rvalid0, a.rvalid0); end
        @(negedge clk); reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++; if (f.rvalid0 !== 1'b0 || a.rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_late_rvalid cyc=%0d got=%b%b exp=00", i, f.rvalid0, a.rvalid0); end
        end
        total++; if ({f.gcnt0, f.gcnt1, a.gcnt0, a.gcnt1} !== 64'h0) begin bad++; $display("FAIL mid_gcnt got=%0d/%0d/%0d/%0d exp=0", f.gcnt0, f.gcnt1, a.gcnt0, a.gcnt1); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_arb_en();
        test_withdraw();
        test_fixed_prio();
        test_latency3();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
